// File: rtl/vc_traffic_source.sv
// vc_traffic_source
//   Transmitter end of the QoS ingress interface. It emits per-VC word
//   streams and obeys per-VC flow control from the QoS block. Each cycle,
//   one eligible VC is chosen round-robin.
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   enb             global enable (low freezes state, suppresses wr_en/done)
//   iniciar         start-burst pulse, honoured only in IDLE
//   cuenta          per-VC word counts, VC i at cuenta[i*CW +: CW]
//   pausa           per-VC pause request
//   continuar       per-VC resume request
//   error_full      per-VC overflow error (aborts that VC)
//   vc_id           target VC of the current word
//   data_word       current word payload
//   wr_en           word valid this cycle
//   idle            FSM is in IDLE
//   done            one-cycle pulse at burst completion
//   vc_error        sticky per-VC abort flags
module vc_traffic_source #(
    parameter  int QUEUE_QUANTITY = 4,
    parameter  int BUF_WIDTH      = 3,
    parameter  int MAX_WORDS      = 16,
    localparam int CW             = $clog2(MAX_WORDS + 1),
    localparam int VW             = $clog2(QUEUE_QUANTITY)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enb,
    input  logic                         iniciar,
    input  logic [QUEUE_QUANTITY*CW-1:0] cuenta,
    input  logic [QUEUE_QUANTITY-1:0]    pausa,
    input  logic [QUEUE_QUANTITY-1:0]    continuar,
    input  logic [QUEUE_QUANTITY-1:0]    error_full,
    output logic [VW-1:0]                vc_id,
    output logic [BUF_WIDTH:0]           data_word,
    output logic                         wr_en,
    output logic                         idle,
    output logic                         done,
    output logic [QUEUE_QUANTITY-1:0]    vc_error
);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                      state;
    logic [CW-1:0]               rem [QUEUE_QUANTITY];
    logic [CW-1:0]               seq [QUEUE_QUANTITY];
    logic [QUEUE_QUANTITY-1:0]   pause;
    logic [VW-1:0]               ptr;

    logic [QUEUE_QUANTITY-1:0]   elig;
    logic                        pending;
    logic                        win_found;
    logic [VW-1:0]               win;
    logic [VW-1:0]               cand;
    logic [VW-1:0]               nxt_ptr;
    logic [BUF_WIDTH:0]          word;

    // Arbitration: scan cyclically from ptr, first eligible VC wins.
    // pending ignores pause so that paused VCs with work keep the FSM in SEND.
    always_comb begin
        elig      = '0;
        pending   = 1'b0;
        win_found = 1'b0;
        win       = '0;
        cand      = '0;
        for (int unsigned k = 0; k < QUEUE_QUANTITY; k++) begin
            elig[k] = (rem[k] != '0) && !pause[k] && !vc_error[k];
            pending = pending | ((rem[k] != '0) && !vc_error[k]);
        end
        for (int unsigned off = 0; off < QUEUE_QUANTITY; off++) begin
            cand = VW'((32'(ptr) + off) % QUEUE_QUANTITY);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
        word    = (BUF_WIDTH + 1)'(32'(win) * 32'd4 + 32'(seq[win]));
        nxt_ptr = VW'((32'(win) + 32'd1) % QUEUE_QUANTITY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vc_id     <= '0;
            data_word <= '0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            idle      <= 1'b1;
            vc_error  <= '0;
            pause     <= '0;
            ptr       <= '0;
            for (int unsigned k = 0; k < QUEUE_QUANTITY; k++) begin
                rem[k] <= '0;
                seq[k] <= '0;
            end
        end else if (!enb) begin
            // Freeze: state holds; done is also dropped so a freeze while
            // in DONE cannot stretch the completion pulse.
            wr_en <= 1'b0;
            done  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (iniciar) begin
                        for (int unsigned k = 0; k < QUEUE_QUANTITY; k++) begin
                            rem[k] <= cuenta[k*CW +: CW];
                            seq[k] <= '0;
                        end
                        pause    <= '0;
                        vc_error <= '0;
                        ptr      <= '0;
                        idle     <= 1'b0;
                        if (cuenta == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (!pending) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (win_found) begin
                        wr_en     <= 1'b1;
                        vc_id     <= win;
                        data_word <= word;
                        rem[win]  <= rem[win] - 1'b1;
                        seq[win]  <= seq[win] + 1'b1;
                        ptr       <= nxt_ptr;
                    end
                    // Flag sampling comes after the word update so that an
                    // abort's rem clear overrides a same-cycle decrement.
                    for (int unsigned k = 0; k < QUEUE_QUANTITY; k++) begin
                        if (pausa[k]) begin
                            pause[k] <= 1'b1;
                        end else if (continuar[k]) begin
                            pause[k] <= 1'b0;
                        end
                        if (error_full[k]) begin
                            vc_error[k] <= 1'b1;
                            rem[k]      <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vc_traffic_source.sv
module tb_vc_traffic_source;

    localparam int Q  = 4;
    localparam int BW = 3;
    localparam int MW = 16;
    localparam int CW = $clog2(MW + 1);

    logic            clk = 1'b0;
    logic            rst, enb, iniciar;
    logic [Q*CW-1:0] cuenta;
    logic [Q-1:0]    pausa, continuar, error_full;
    logic [1:0]      vc_id;
    logic [BW:0]     data_word;
    logic            wr_en, idle, done;
    logic [Q-1:0]    vc_error;

    vc_traffic_source #(.QUEUE_QUANTITY(Q), .BUF_WIDTH(BW), .MAX_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .enb(enb), .iniciar(iniciar), .cuenta(cuenta),
        .pausa(pausa), .continuar(continuar), .error_full(error_full),
        .vc_id(vc_id), .data_word(data_word), .wr_en(wr_en), .idle(idle),
        .done(done), .vc_error(vc_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (burst-level rules) ----------------
    typedef struct {int vc; int data;} word_t;
    word_t wq[$];      // expected words, pushed by the model
    int    dq[$];      // expected done cycles
    word_t log_q[$];   // observed words
    int    cyc = 0;

    int m_st;          // 0 idle, 1 sending, 2 finishing
    int m_rem [Q];
    int m_seq [Q];
    bit m_pause [Q];
    bit m_err [Q];
    int m_ptr, m_sum, m_w;
    bit m_busy, m_found;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st = 0; m_ptr = 0;
            for (int i = 0; i < Q; i++) begin
                m_rem[i] = 0; m_seq[i] = 0; m_pause[i] = 0; m_err[i] = 0;
            end
            wq.delete(); dq.delete();
        end else begin
            cyc++;
            if (enb) begin
                case (m_st)
                    0: if (iniciar) begin
                        m_sum = 0;
                        for (int i = 0; i < Q; i++) begin
                            m_rem[i] = int'(cuenta[i*CW +: CW]);
                            m_sum += m_rem[i];
                            m_seq[i] = 0; m_pause[i] = 0; m_err[i] = 0;
                        end
                        m_ptr = 0;
                        if (m_sum == 0) begin m_st = 2; dq.push_back(cyc); end
                        else m_st = 1;
                    end
                    1: begin
                        m_busy = 0;
                        for (int i = 0; i < Q; i++)
                            if (m_rem[i] > 0 && !m_err[i]) m_busy = 1;
                        if (!m_busy) begin
                            m_st = 2; dq.push_back(cyc);
                        end else begin
                            m_found = 0;
                            for (int d = 0; d < Q; d++) begin
                                m_w = (m_ptr + d) % Q;
                                if (!m_found && m_rem[m_w] > 0 && !m_pause[m_w] && !m_err[m_w]) begin
                                    m_found = 1;
                                    wq.push_back('{m_w, (m_w * 4 + m_seq[m_w]) % (1 << (BW + 1))});
                                    m_rem[m_w]--;
                                    m_seq[m_w] = (m_seq[m_w] + 1) % (1 << CW);
                                    m_ptr = (m_w + 1) % Q;
                                end
                            end
                        end
                        for (int i = 0; i < Q; i++) begin
                            if (pausa[i]) m_pause[i] = 1;
                            else if (continuar[i]) m_pause[i] = 0;
                            if (error_full[i]) begin m_err[i] = 1; m_rem[i] = 0; end
                        end
                    end
                    default: m_st = 0;
                endcase
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    word_t       e;
    logic [Q-1:0] em;
    always @(negedge clk) begin
        for (int i = 0; i < Q; i++) em[i] = m_err[i];
        check("idle", int'(idle), int'(m_st == 0));
        check("vc_error", int'(vc_error), int'(em));
        if (wr_en) begin
            if (wq.size() == 0) check("unexpected_wr", int'(wr_en), 0);
            else begin
                e = wq.pop_front();
                check("vc_id", int'(vc_id), e.vc);
                check("data_word", int'(data_word), e.data);
            end
            log_q.push_back('{int'(vc_id), int'(data_word)});
        end
        if (done) begin
            if (dq.size() == 0) check("unexpected_done", int'(done), 0);
            else check("done_cycle", cyc, dq.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int c0, input int c1, input int c2, input int c3);
        cuenta  = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!(m_st == 0 && idle) && n < max) begin step(); n++; end
        check("burst_timeout", int'(n < max), 1);
        check("words_left", wq.size(), 0);
    endtask

    task automatic wait_words(input int cnt, input int max);
        int n = 0;
        while (log_q.size() < cnt && n < max) begin step(); n++; end
        check("word_wait_timeout", int'(log_q.size() >= cnt), 1);
    endtask

    int exp_vc [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_d  [8] = '{0, 4, 8, 12, 1, 5, 9, 13};
    int cnt_vc [Q];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enb = 1'b1; iniciar = 1'b0; cuenta = '0;
        pausa = '0; continuar = '0; error_full = '0;
        step(); step();
        check("rst_idle", int'(idle), 1);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_done", int'(done), 0);
        check("rst_vc_id", int'(vc_id), 0);
        check("rst_data", int'(data_word), 0);
        rst = 1'b0;
        step();

        // 1: all VCs two words, strict round-robin order
        log_q.delete();
        start(2, 2, 2, 2);
        wait_done(60);
        check("t1_count", log_q.size(), 8);
        for (int k = 0; k < 8 && k < log_q.size(); k++) begin
            check("t1_vc", log_q[k].vc, exp_vc[k]);
            check("t1_data", log_q[k].data, exp_d[k]);
        end

        // 2: pause after second word, at most one more in flight
        log_q.delete();
        start(4, 0, 0, 0);
        wait_words(2, 20);
        pausa[0] = 1'b1; step(); pausa[0] = 1'b0;
        repeat (4) step();
        check("t2_paused_count", log_q.size(), 3);
        continuar[0] = 1'b1; step(); continuar[0] = 1'b0;
        wait_done(40);
        check("t2_count", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            check("t2_data", log_q[k].data, k);

        // 3: abort VC2 after its first word
        log_q.delete();
        start(3, 3, 3, 3);
        wait_words(3, 20);
        error_full[2] = 1'b1; step(); error_full[2] = 1'b0;
        wait_done(60);
        check("t3_vc_error", int'(vc_error), 4);
        for (int i = 0; i < Q; i++) cnt_vc[i] = 0;
        foreach (log_q[k]) cnt_vc[log_q[k].vc]++;
        check("t3_vc0", cnt_vc[0], 3);
        check("t3_vc1", cnt_vc[1], 3);
        check("t3_vc2", cnt_vc[2], 1);
        check("t3_vc3", cnt_vc[3], 3);

        // 4: freeze mid-burst
        log_q.delete();
        start(3, 3, 3, 3);
        repeat (3) step();
        enb = 1'b0;
        repeat (3) begin step(); check("t4_frozen_wr", int'(wr_en), 0); end
        enb = 1'b1;
        wait_done(60);
        check("t4_count", log_q.size(), 12);
        for (int k = 0; k < 12 && k < log_q.size(); k++) begin
            check("t4_vc", log_q[k].vc, k % 4);
            check("t4_data", log_q[k].data, (k % 4) * 4 + k / 4);
        end

        // 5: async reset mid-burst, then restart from seq 0
        log_q.delete();
        start(3, 3, 3, 3);
        wait_words(5, 20);
        rst = 1'b1;
        #1;
        check("t5_wr_en", int'(wr_en), 0);
        check("t5_vc_id", int'(vc_id), 0);
        check("t5_data", int'(data_word), 0);
        check("t5_done", int'(done), 0);
        check("t5_vc_error", int'(vc_error), 0);
        check("t5_idle", int'(idle), 1);
        step();
        rst = 1'b0;
        log_q.delete();
        start(1, 1, 1, 1);
        wait_done(40);
        check("t5_count", log_q.size(), 4);
        for (int k = 0; k < 4 && k < log_q.size(); k++)
            check("t5_restart_data", log_q[k].data, k * 4);

        // 6: empty burst
        log_q.delete();
        start(0, 0, 0, 0);
        check("t6_done", int'(done), 1);
        check("t6_not_idle", int'(idle), 0);
        step();
        check("t6_done_end", int'(done), 0);
        check("t6_idle", int'(idle), 1);
        check("t6_no_words", log_q.size(), 0);

        // random bursts with random flow control and freezes
        for (int b = 0; b < 30; b++) begin
            start($urandom_range(0, MW), $urandom_range(0, MW),
                  $urandom_range(0, MW), $urandom_range(0, MW));
            for (int c = 0; c < 300 && m_st != 0; c++) begin
                enb = ($urandom_range(0, 7) != 0);
                iniciar = ($urandom_range(0, 15) == 0);
                for (int i = 0; i < Q; i++) begin
                    pausa[i]      = ($urandom_range(0, 7) == 0);
                    continuar[i]  = ($urandom_range(0, 3) == 0);
                    error_full[i] = ($urandom_range(0, 39) == 0);
                end
                step();
            end
            enb = 1'b1; iniciar = 1'b0; pausa = '0; error_full = '0;
            continuar = '1;
            wait_done(200);
            continuar = '0;
            step();
        end

        check("final_words_left", wq.size(), 0);
        check("final_done_left", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
